// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the RV32I front end: NOP encoding,
// reset PC default and fetch FSM state encoding.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } fetch_state_e;

    // Word-aligned redirect address; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    // NOTE: reset is synchronous, so rst_n is sampled only inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction side of the
// shared memory port and produces the IF/ID pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [XLEN-1:0] if_id_inst,
    output logic            if_id_valid,
    output logic            fetch_misaligned,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_if_id_pc;
    logic [31:0]  r_if_id_pc_plus4;
    logic [31:0]  r_if_id_inst;
    logic         r_if_id_valid;
    logic         r_misaligned;

    logic         w_active;
    logic         w_redirect;
    logic         w_stall_evt;
    logic         w_fetch;
    logic [31:0]  w_pc_plus4;

    // BOOT ignores both redirect and stall; otherwise redirect beats stall.
    assign w_active    = (r_state != ST_BOOT);
    assign w_redirect  = w_active && branch_taken;
    assign w_stall_evt = w_active && !branch_taken && stall;
    assign w_fetch     = w_active && !branch_taken && !stall;
    assign w_pc_plus4  = r_pc + 32'd4;

    assign imem_req  = w_fetch;
    assign imem_addr = r_pc;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ST_BOOT;
            r_pc             <= RESET_PC;
            r_if_id_pc       <= '0;
            r_if_id_pc_plus4 <= '0;
            r_if_id_inst     <= NOP_INST;
            r_if_id_valid    <= 1'b0;
            r_misaligned     <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN, ST_STALL: begin
                    if (w_redirect) begin
                        r_pc          <= align_word(branch_target);
                        r_if_id_inst  <= NOP_INST;
                        r_if_id_valid <= 1'b0;
                        r_misaligned  <= (branch_target[1:0] != 2'b00);
                        r_state       <= ST_RUN;
                    end else if (w_stall_evt) begin
                        r_state <= ST_STALL;
                    end else begin
                        r_if_id_pc       <= r_pc;
                        r_if_id_pc_plus4 <= w_pc_plus4;
                        r_if_id_inst     <= imem_rdata;
                        r_if_id_valid    <= 1'b1;
                        r_pc             <= w_pc_plus4;
                        r_state          <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign if_id_pc         = r_if_id_pc;
    assign if_id_pc_plus4   = r_if_id_pc_plus4;
    assign if_id_inst       = r_if_id_inst;
    assign if_id_valid      = r_if_id_valid;
    assign fetch_misaligned = r_misaligned;

    sat_counter u_fetch_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_fetch),
        .o_count (fetch_count)
    );

    sat_counter u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_stall_evt),
        .o_count (stall_count)
    );

endmodule
